// File: rtl/uwasic_pkg.sv
// Shared SPI/PWM register map, frame layout and bus widths.
package uwasic_pkg;

  localparam int unsigned REG_W          = 8;
  localparam int unsigned ADDR_W         = 7;
  localparam int unsigned REG_COUNT      = 5;
  localparam int unsigned SPI_FRAME_BITS = 16;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  localparam logic SPI_WRITE = 1'b1;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } spi_frame_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pins in, PWM control registers out.
interface spi_peripheral_if;
  import uwasic_pkg::*;

  logic             sclk;
  logic             copi;
  logic             ncs;
  logic [REG_W-1:0] en_reg_out_7_0;
  logic [REG_W-1:0] en_reg_out_15_8;
  logic [REG_W-1:0] en_reg_pwm_7_0;
  logic [REG_W-1:0] en_reg_pwm_15_8;
  logic [REG_W-1:0] pwm_duty_cycle;

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
  );

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
  );

endinterface

// File: rtl/spi_peripheral_sync_edge_det.sv
// Multi-stage synchroniser plus one history FF for rise/fall detection.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], din};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign level  = chain_q[SYNC_STAGES-1];
  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register file driving the PWM control registers.
module spi_peripheral
  import uwasic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned NUM_REGS    = 5
) (
  input logic            clk,
  input logic            rst_n,
  spi_peripheral_if.slave bus
);

  localparam int unsigned       CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);

  logic sclk_lvl, sclk_rise_c, unused_sclk_fall_c;
  logic copi_lvl, unused_copi_rise_c, unused_copi_fall_c;
  logic ncs_lvl, ncs_rise_c, ncs_fall_c;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(bus.sclk),
    .level(sclk_lvl), .rise_c(sclk_rise_c), .fall_c(unused_sclk_fall_c)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(bus.copi),
    .level(copi_lvl), .rise_c(unused_copi_rise_c), .fall_c(unused_copi_fall_c)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(bus.ncs),
    .level(ncs_lvl), .rise_c(ncs_rise_c), .fall_c(ncs_fall_c)
  );

  logic [SPI_FRAME_BITS-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]          cnt_q, cnt_nxt;
  spi_frame_t                frame_c;
  logic                      commit_c;
  logic [REG_W-1:0]          regs_q [REG_COUNT];

  // Next shift/count; an sclk rise coincident with the ncs rise still shifts
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    if (ncs_fall_c) begin
      shift_nxt = '0;
      cnt_nxt   = '0;
    end else if (sclk_rise_c && (!ncs_lvl || ncs_rise_c)) begin
      shift_nxt = {shift_q[SPI_FRAME_BITS-2:0], copi_lvl};
      if (cnt_q != CNT_SAT) begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  assign frame_c  = spi_frame_t'(shift_nxt);
  assign commit_c = ncs_rise_c && (cnt_nxt == CNT_FULL) && (frame_c.rw == SPI_WRITE)
                    && (frame_c.addr < ADDR_W'(NUM_REGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Only the addressed register loads, so the others never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_c) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (frame_c.addr == ADDR_W'(i)) begin
          regs_q[i] <= frame_c.data;
        end
      end
    end
  end

  assign bus.en_reg_out_7_0  = regs_q[int'(ADDR_EN_OUT_LO)];
  assign bus.en_reg_out_15_8 = regs_q[int'(ADDR_EN_OUT_HI)];
  assign bus.en_reg_pwm_7_0  = regs_q[int'(ADDR_EN_PWM_LO)];
  assign bus.en_reg_pwm_15_8 = regs_q[int'(ADDR_EN_PWM_HI)];
  assign bus.pwm_duty_cycle  = regs_q[int'(ADDR_PWM_DUTY)];

endmodule
